audio_playback_sequencer: RTL

- Sequences sample playback from the signed 8-bit sample ROM path, and mixes in pseudo-random noise from the 8-bit LFSR at a programmable sample rate.
- Emits one saturated signed 8-bit sample per sample tick, with a valid strobe, for the downstream audio/display logic.
- Sits between the top-level control (start/stop/mode from the voice UI) and the existing sample-memory and LFSR instances.

---
 rtl/audio_pkg.sv | 24 ++
 rtl/sample_tick_gen.sv | 34 +++
 rtl/audio_playback_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio playback path.
//   mode_t   : voice-UI mix mode encodings
//   state_t  : playback sequencer FSM states
//   SAMPLE_MAX / SAMPLE_MIN : signed 8-bit output saturation limits
package audio_pkg;

    typedef enum logic [1:0] {
        MODE_MEM   = 2'b00,
        MODE_NOISE = 2'b01,
        MODE_MIX   = 2'b10,
        MODE_MUTE  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        FETCH,
        MIX
    } state_t;

    localparam int SAMPLE_MAX = 127;
    localparam int SAMPLE_MIN = -128;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick generator.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   en    : count enable; counter is held at 0 while low
//   tick  : high for one cycle when the count reaches CLK_DIV-1
module sample_tick_gen #(
    parameter int CLK_DIV = 12500
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int              CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    // Holding the count at 0 while disabled gives every playback a
    // fresh CLK_DIV-cycle first period without a separate clear input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!en || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/audio_playback_sequencer.sv
// Playback sequencer: reads signed samples from sample memory, optionally
// mixes in LFSR noise, saturates, and emits one sample per sample tick.
//   clk, reset          : system clock, async active-low reset
//   start, stop         : single-cycle control pulses
//   loop_en             : wrap to address 0 after the last sample
//   mode, noise_gain    : mix mode and noise amplitude (latched per tick)
//   mem_en, mem_addr    : sample memory read port (data 1 cycle later)
//   mem_data            : sample memory read data
//   lfsr_8bit           : free-running noise source
//   sample_out/_valid   : saturated output sample and its strobe
//   busy, done          : activity flag, end-of-buffer pulse
module audio_playback_sequencer
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 12500,
    parameter int ADDR_W  = 14,
    parameter int DEPTH   = 16000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    input  logic [1:0]          mode,
    input  logic [1:0]          noise_gain,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic signed [7:0]   mem_data,
    input  logic [7:0]          lfsr_8bit,
    output logic signed [7:0]   sample_out,
    output logic                sample_valid,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic signed [8:0] SUM_MAX   = 9'(SAMPLE_MAX);
    localparam logic signed [8:0] SUM_MIN   = 9'(SAMPLE_MIN);
    localparam logic signed [7:0] OUT_MAX   = 8'(SAMPLE_MAX);
    localparam logic signed [7:0] OUT_MIN   = 8'(SAMPLE_MIN);

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  mem_en_q, mem_en_d;
    logic signed [7:0]     sample_q, sample_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    mode_t                 mode_q, mode_d;
    logic [1:0]            gain_q, gain_d;

    logic                  tick;
    logic signed [7:0]     noise;
    logic signed [8:0]     sum;
    logic signed [7:0]     mixed;

    sample_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (busy_q),
        .tick  (tick)
    );

    // Mixing datapath, evaluated during MIX using the latched mode/gain.
    always_comb begin
        noise = $signed(lfsr_8bit) >>> (2'd3 - gain_q);
        case (mode_q)
            MODE_MEM:   sum = {mem_data[7], mem_data};
            MODE_NOISE: sum = {noise[7], noise};
            MODE_MIX:   sum = {mem_data[7], mem_data} + {noise[7], noise};
            default:    sum = '0;
        endcase
        if (sum > SUM_MAX) begin
            mixed = OUT_MAX;
        end else if (sum < SUM_MIN) begin
            mixed = OUT_MIN;
        end else begin
            mixed = sum[7:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        mem_en_d = 1'b0;
        sample_d = sample_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        mode_d   = mode_q;
        gain_d   = gain_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_TICK;
                    addr_d  = '0;
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    mode_d   = mode_t'(mode);
                    gain_d   = noise_gain;
                    mem_en_d = !(mode_t'(mode) inside {MODE_NOISE, MODE_MUTE});
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                state_d = MIX;
            end
            MIX: begin
                sample_d = mixed;
                valid_d  = 1'b1;
                if (addr_q != LAST_ADDR) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = WAIT_TICK;
                end else begin
                    addr_d = '0;
                    if (loop_en) begin
                        state_d = WAIT_TICK;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // stop overrides every transition above, including end-of-buffer.
        if (stop && state_q != IDLE) begin
            state_d  = IDLE;
            addr_d   = '0;
            mem_en_d = 1'b0;
            sample_d = sample_q;
            valid_d  = 1'b0;
            done_d   = 1'b0;
            mode_d   = mode_q;
            gain_d   = gain_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            mem_en_q <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            mode_q   <= MODE_MEM;
            gain_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            mem_en_q <= mem_en_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            mode_q   <= mode_d;
            gain_q   <= gain_d;
        end
    end

    assign mem_en       = mem_en_q;
    assign mem_addr     = addr_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
